// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decode-stage payload with stall (write=0) and flush (bubble).
// Optional: define ID_EX_BUBBLE_CNT_EN to add a saturating 16-bit bubble counter output.
module id_ex_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic [7:0]            ctrl_in,
    input  logic [DATA_WIDTH-1:0] PC_in,
    input  logic [DATA_WIDTH-1:0] RD1_in,
    input  logic [DATA_WIDTH-1:0] RD2_in,
    input  logic [DATA_WIDTH-1:0] IMM_in,
    input  logic [2:0]            FUNCT3_in,
    input  logic [6:0]            FUNCT7_in,
    input  logic [4:0]            RS1_in,
    input  logic [4:0]            RS2_in,
    input  logic [4:0]            RD_in,
    output logic [7:0]            ctrl_ex,
    output logic [DATA_WIDTH-1:0] PC_ex,
    output logic [DATA_WIDTH-1:0] RD1_ex,
    output logic [DATA_WIDTH-1:0] RD2_ex,
    output logic [DATA_WIDTH-1:0] IMM_ex,
    output logic [2:0]            FUNCT3_ex,
    output logic [6:0]            FUNCT7_ex,
    output logic [4:0]            RS1_ex,
    output logic [4:0]            RS2_ex,
    output logic [4:0]            RD_ex,
    output logic                  valid_ex
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [15:0]           bubble_cnt
`endif
);

    typedef struct packed {
        logic                  valid;
        logic [7:0]            ctrl;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] rd1;
        logic [DATA_WIDTH-1:0] rd2;
        logic [DATA_WIDTH-1:0] imm;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
    } stage_t;

    stage_t in_s;
    stage_t stage_d;
    stage_t stage_q;

    // A non-valid slot must never carry live control, so ctrl is gated by valid_in.
    always_comb begin
        in_s        = '0;
        in_s.valid  = valid_in;
        in_s.ctrl   = valid_in ? ctrl_in : 8'h00;
        in_s.pc     = PC_in;
        in_s.rd1    = RD1_in;
        in_s.rd2    = RD2_in;
        in_s.imm    = IMM_in;
        in_s.funct3 = FUNCT3_in;
        in_s.funct7 = FUNCT7_in;
        in_s.rs1    = RS1_in;
        in_s.rs2    = RS2_in;
        in_s.rd     = RD_in;
    end

    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (write) begin
            stage_d = in_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign valid_ex  = stage_q.valid;
    assign ctrl_ex   = stage_q.ctrl;
    assign PC_ex     = stage_q.pc;
    assign RD1_ex    = stage_q.rd1;
    assign RD2_ex    = stage_q.rd2;
    assign IMM_ex    = stage_q.imm;
    assign FUNCT3_ex = stage_q.funct3;
    assign FUNCT7_ex = stage_q.funct7;
    assign RS1_ex    = stage_q.rs1;
    assign RS2_ex    = stage_q.rs2;
    assign RD_ex     = stage_q.rd;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] bcnt_d;
    logic [15:0] bcnt_q;
    logic        bubble;

    // A bubble is either an explicit flush or a captured non-valid slot.
    assign bubble = flush | (write & ~valid_in);

    always_comb begin
        bcnt_d = bcnt_q;
        if (bubble && (bcnt_q != 16'hFFFF)) begin
            bcnt_d = bcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt_q <= 16'h0000;
        end else begin
            bcnt_q <= bcnt_d;
        end
    end

    assign bubble_cnt = bcnt_q;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg; bubble counter checks compile in with ID_EX_BUBBLE_CNT_EN.
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        reset, write, flush, valid_in;
    logic [7:0]  ctrl_in;
    logic [31:0] PC_in, RD1_in, RD2_in, IMM_in;
    logic [2:0]  FUNCT3_in;
    logic [6:0]  FUNCT7_in;
    logic [4:0]  RS1_in, RS2_in, RD_in;
    logic [7:0]  ctrl_ex;
    logic [31:0] PC_ex, RD1_ex, RD2_ex, IMM_ex;
    logic [2:0]  FUNCT3_ex;
    logic [6:0]  FUNCT7_ex;
    logic [4:0]  RS1_ex, RS2_ex, RD_ex;
    logic        valid_ex;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_reg #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .write(write), .flush(flush), .valid_in(valid_in),
        .ctrl_in(ctrl_in), .PC_in(PC_in), .RD1_in(RD1_in), .RD2_in(RD2_in), .IMM_in(IMM_in),
        .FUNCT3_in(FUNCT3_in), .FUNCT7_in(FUNCT7_in), .RS1_in(RS1_in), .RS2_in(RS2_in),
        .RD_in(RD_in),
        .ctrl_ex(ctrl_ex), .PC_ex(PC_ex), .RD1_ex(RD1_ex), .RD2_ex(RD2_ex), .IMM_ex(IMM_ex),
        .FUNCT3_ex(FUNCT3_ex), .FUNCT7_ex(FUNCT7_ex), .RS1_ex(RS1_ex), .RS2_ex(RS2_ex),
        .RD_ex(RD_ex), .valid_ex(valid_ex)
`ifdef ID_EX_BUBBLE_CNT_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string t, input logic [7:0] c, input logic [31:0] pc,
                           input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [4:0] d, input logic v);
        chk({t, ".ctrl"},   {24'h0, ctrl_ex},   {24'h0, c});
        chk({t, ".pc"},     PC_ex,              pc);
        chk({t, ".rd1"},    RD1_ex,             r1);
        chk({t, ".rd2"},    RD2_ex,             r2);
        chk({t, ".imm"},    IMM_ex,             im);
        chk({t, ".funct3"}, {29'h0, FUNCT3_ex}, {29'h0, f3});
        chk({t, ".funct7"}, {25'h0, FUNCT7_ex}, {25'h0, f7});
        chk({t, ".rs1"},    {27'h0, RS1_ex},    {27'h0, s1});
        chk({t, ".rs2"},    {27'h0, RS2_ex},    {27'h0, s2});
        chk({t, ".rd"},     {27'h0, RD_ex},     {27'h0, d});
        chk({t, ".valid"},  {31'h0, valid_ex},  {31'h0, v});
    endtask

    task automatic chk_cnt(input string t, input logic [15:0] exp);
`ifdef ID_EX_BUBBLE_CNT_EN
        chk({t, ".bcnt"}, {16'h0, bubble_cnt}, {16'h0, exp});
`endif
    endtask

    task automatic drive(input logic [7:0] c, input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] im, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d);
        ctrl_in = c; PC_in = pc; RD1_in = r1; RD2_in = r2; IMM_in = im;
        FUNCT3_in = f3; FUNCT7_in = f7; RS1_in = s1; RS2_in = s2; RD_in = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; write = 1'b1; flush = 1'b0; valid_in = 1'b1;
        drive(8'hFF, 32'hDEAD_BEEF, 32'h1, 32'h2, 32'h3, 3'h7, 7'h7F, 5'h1F, 5'h1F, 5'h1F);
        #2;
        // reset beats write with all-ones control
        step();
        chk_all("rst", 8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 3'h0, 7'h0, 5'h0, 5'h0, 5'h0, 1'b0);
        chk_cnt("rst", 16'h0000);

        // basic capture
        reset = 1'b0;
        drive(8'h96, 32'h40, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFF0, 3'h5, 7'h20,
              5'd3, 5'd4, 5'd5);
        step();
        chk_all("cap", 8'h96, 32'h40, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFF0, 3'h5,
                7'h20, 5'd3, 5'd4, 5'd5, 1'b1);

        // stall 3 cycles with changing inputs
        write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_in = i[0];
            drive(8'h11 + 8'(i), 32'h100 + 32'(i), 32'hA, 32'hB, 32'hC, 3'(i), 7'(i),
                  5'(i), 5'(i), 5'(10 + i));
            step();
            chk_all("hold", 8'h96, 32'h40, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFF0,
                    3'h5, 7'h20, 5'd3, 5'd4, 5'd5, 1'b1);
            chk_cnt("hold", 16'h0000);
        end

        // flush wins over write
        flush = 1'b1; write = 1'b1; valid_in = 1'b1;
        drive(8'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'h7, 7'h7F,
              5'h1F, 5'h1F, 5'h1F);
        step();
        chk_all("flush", 8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 3'h0, 7'h0, 5'h0, 5'h0, 5'h0, 1'b0);
        chk_cnt("flush", 16'h0001);

        // non-valid capture zeroes ctrl only
        flush = 1'b0; valid_in = 1'b0;
        drive(8'hC3, 32'h80, 32'h33, 32'h44, 32'h55, 3'h2, 7'h01, 5'd8, 5'd9, 5'd7);
        step();
        chk_all("nv", 8'h00, 32'h80, 32'h33, 32'h44, 32'h55, 3'h2, 7'h01, 5'd8, 5'd9, 5'd7, 1'b0);
        chk_cnt("nv", 16'h0002);

        // zero-control bubble from upstream stays valid
        valid_in = 1'b1;
        drive(8'h00, 32'h84, 32'h66, 32'h77, 32'h88, 3'h1, 7'h00, 5'd1, 5'd2, 5'd6);
        step();
        chk_all("z", 8'h00, 32'h84, 32'h66, 32'h77, 32'h88, 3'h1, 7'h00, 5'd1, 5'd2, 5'd6, 1'b1);
        chk_cnt("z", 16'h0002);

        // asymmetric control pattern checks bit order
        drive(8'h5A, 32'h88, 32'h9, 32'hA, 32'hB, 3'h3, 7'h40, 5'd10, 5'd11, 5'd12);
        step();
        chk_all("ord", 8'h5A, 32'h88, 32'h9, 32'hA, 32'hB, 3'h3, 7'h40, 5'd10, 5'd11, 5'd12, 1'b1);

        // stall with valid_in=0 must not count
        write = 1'b0; valid_in = 1'b0;
        step();
        step();
        chk_all("st2", 8'h5A, 32'h88, 32'h9, 32'hA, 32'hB, 3'h3, 7'h40, 5'd10, 5'd11, 5'd12, 1'b1);
        chk_cnt("st2", 16'h0002);

        // reset mid-stall discards contents
        reset = 1'b1;
        step();
        chk_all("rst2", 8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 3'h0, 7'h0, 5'h0, 5'h0, 5'h0, 1'b0);
        chk_cnt("rst2", 16'h0000);

        // first capture waits for write after reset release
        reset = 1'b0; valid_in = 1'b1;
        drive(8'h81, 32'hC0, 32'h1, 32'h2, 32'h3, 3'h4, 7'h05, 5'd13, 5'd14, 5'd15);
        step();
        chk("post.valid", {31'h0, valid_ex}, 32'h0);
        chk("post.pc", PC_ex, 32'h0);
        write = 1'b1;
        step();
        chk_all("first", 8'h81, 32'hC0, 32'h1, 32'h2, 32'h3, 3'h4, 7'h05, 5'd13, 5'd14, 5'd15, 1'b1);

`ifdef ID_EX_BUBBLE_CNT_EN
        // drive the counter to FFFE, then confirm saturation
        flush = 1'b1;
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #1;
        chk_cnt("pre", 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_cnt("sat", 16'hFFFF);
        end
        flush = 1'b0; write = 1'b0;
        step();
        chk_cnt("sathold", 16'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 The block SHALL have a parameter DATA_WIDTH, default 32, setting the width of PC, operand and immediate fields.
REQ-002 The block SHALL have the port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have the port write, input, 1, the capture enable; 0 means stall/hold.
REQ-005 The block SHALL have the port flush, input, 1, the request to insert a bubble.
REQ-006 The block SHALL have the port valid_in, input, 1, marking the ID-stage instruction as real.
REQ-007 The block SHALL have the port ctrl_in, input, 8, packed {RegWrite,MemtoReg,Branch,MemRead,MemWrite,ALUSrc,ALUop[1:0]} from the decode control unit.
REQ-008 The block SHALL have the ports PC_in, RD1_in, RD2_in and IMM_in, each input, DATA_WIDTH, carrying PC, register-file read data 1 and 2, and the sign-extended immediate.
REQ-009 The block SHALL have the ports FUNCT3_in (input, 3), FUNCT7_in (input, 7), RS1_in (input, 5), RS2_in (input, 5) and RD_in (input, 5), carrying the instruction fields.
REQ-010 The block SHALL have one registered output per input field, named ctrl_ex, PC_ex, RD1_ex, RD2_ex, IMM_ex, FUNCT3_ex, FUNCT7_ex, RS1_ex, RS2_ex and RD_ex, each matching its input width.
REQ-011 The block SHALL have the port valid_ex, output, 1, marking a real instruction in EX.
REQ-012 The block SHALL drive every output directly from a flip-flop, with no combinational path from input to output.

Function
REQ-013 On each rising clk edge the block SHALL apply exactly one action, chosen in priority order reset > flush > write > hold.
REQ-014 When flush=1 and reset=0, the block SHALL load ctrl_ex=0, valid_ex=0 and all data/field outputs =0, regardless of write.
REQ-015 When write=1, flush=0 and reset=0, the block SHALL capture every _in field into its _ex output and valid_in into valid_ex, with 1-cycle latency.
REQ-016 When write=0, flush=0 and reset=0, the block SHALL hold every output unchanged, for any number of cycles.
REQ-017 When valid_in=0 is captured, the block SHALL also force ctrl_ex=0, so that a non-valid slot never asserts RegWrite, MemWrite or MemRead.
REQ-018 When ctrl_in is all zero (an upstream stall bubble) and valid_in=1, the block SHALL capture it unchanged, with valid_ex=1.
REQ-019 The ctrl_ex bit order SHALL equal the ctrl_in bit order, with no reencoding of ALUop.

Reset
REQ-020 When reset=1 at a clk edge, the block SHALL load all outputs with 0, including valid_ex and any optional counter.
REQ-021 Reset SHALL take precedence over simultaneous flush and write, and the first capture SHALL occur at the first edge where reset=0 and write=1.
REQ-022 Reset asserted mid-stall SHALL discard the held contents.

Configuration
REQ-023 When the macro ID_EX_BUBBLE_CNT_EN is defined, the block SHALL add the output bubble_cnt, 16 bits, counting edges where flush=1, or where write=1 with valid_in=0.
REQ-024 With ID_EX_BUBBLE_CNT_EN defined, bubble_cnt SHALL saturate at 16'hFFFF, never wrap, clear on reset and hold during stall.
REQ-025 Without ID_EX_BUBBLE_CNT_EN, the bubble_cnt port and counter logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-026 The bench SHALL cover: reset=1 with write=1 and ctrl_in=8'hFF -> all outputs 0 on the next edge.
REQ-027 The bench SHALL cover: write=1, valid_in=1, ctrl_in=8'h96, PC_in=32'h40, RD_in=5 -> after one edge ctrl_ex=8'h96, PC_ex=32'h40, RD_ex=5, valid_ex=1.
REQ-028 The bench SHALL cover: write=0 for 3 cycles with changing inputs -> outputs hold the last captured values.
REQ-029 The bench SHALL cover: flush=1 and write=1 together with ctrl_in=8'hFF -> ctrl_ex=0, valid_ex=0, data outputs 0; bubble_cnt increments by 1 when ID_EX_BUBBLE_CNT_EN is defined.
REQ-030 The bench SHALL cover: write=1, valid_in=0, ctrl_in=8'hC3 -> ctrl_ex=0 and valid_ex=0, while the other fields are captured.
REQ-031 The bench SHALL cover, with ID_EX_BUBBLE_CNT_EN defined: preload bubble_cnt=16'hFFFE, then 3 flush cycles -> bubble_cnt=16'hFFFF, with no wrap.
